odyssey_video_timing: RTL
=========================

// Module: odyssey_video_timing
// PURPOSE
//  Pixel-clock scheduler and raster sequencer for the Odyssey video path.
//  Divides clk into the ce_pix strobe and runs H/V counters, producing
//  HBlank/VBlank/HSync/VSync for the emu top-level video outputs.
//  The pal and scandouble mode inputs are applied only at frame boundaries.
// PARAMETERS
//  CLK_DIV      4    clk cycles per pixel (even, >=2); halved when scandouble
//  H_TOTAL      228  pixels per line
//  H_ACTIVE     160  visible pixels per line (HBlank from here)
//  H_SYNC_START 180  first HSync pixel
//  H_SYNC_LEN   17   HSync width, pixels
//  V_TOTAL_N    262  lines per NTSC frame
//  V_TOTAL_P    312  lines per PAL frame
//  V_ACTIVE_N   240  visible lines, NTSC
//  V_ACTIVE_P   288  visible lines, PAL
//  V_SYNC_N     244  first VSync line, NTSC
//  V_SYNC_P     296  first VSync line, PAL
//  V_SYNC_LEN   3    VSync height, lines
// PORTS
//  clk          in   1  system clock (clk_sys)
//  reset        in   1  synchronous, active-high
//  pal          in   1  requested mode: 0 NTSC, 1 PAL
//  scandouble   in   1  requested scandoubled output
//  ce_pix       out  1  pixel-enable strobe, one clk wide
//  hcount       out  9  current pixel, 0..H_TOTAL-1
//  vcount       out  9  current line, 0..V_TOTAL-1
//  line_rep     out  1  scandouble only: 0 first, 1 repeated copy of line
//  HBlank       out  1  hcount >= H_ACTIVE
//  VBlank       out  1  vcount >= V_ACTIVE (active mode)
//  HSync        out  1  H_SYNC_START <= hcount < H_SYNC_START+H_SYNC_LEN
//  VSync        out  1  V_SYNC <= vcount < V_SYNC+V_SYNC_LEN (active mode)
//  frame_start  out  1  high with the ce_pix of pixel (0,0)
//  pal_active   out  1  mode currently in effect
// BEHAVIOUR
//  - Pixel period D = CLK_DIV (or CLK_DIV/2 with sd_active). A free-running
//    divider generates ce_pix every D cycles. All other outputs are registered
//    and change only in the cycle ce_pix is high. They describe the pixel
//    that ce_pix strobes.
//  - During reset: ce_pix=0, hcount=vcount=0, line_rep=0, all blank/sync=0,
//    frame_start=0. Mode registers load pal/scandouble directly.
//  - First ce_pix comes on the 1st cycle after reset falls, at (0,0), with
//    frame_start=1. Later ce_pix strobes follow every D cycles.
//  - Each tick: hcount+1. At H_TOTAL-1, hcount wraps to 0 and the line ends.
//  - Line end, normal mode: vcount+1, wrapping to 0 at V_TOTAL-1.
//  - Line end, scandouble: line_rep toggles, and vcount advances only when
//    line_rep was 1. Frame time in clk cycles is the same in both modes.
//  - Frame boundary (last tick of the last line, last copy of that line):
//    pal_active<=pal and sd_active<=scandouble. The new D applies from the
//    next tick, and frame_start pulses with that tick.
//  - Mode inputs changing mid-frame have no effect before the boundary.
//  - Decodes are evaluated on the new counter values and the active-mode
//    constants, so no blank/sync glitch occurs at a wrap.
//  - If reset asserts mid-frame, the next cycle matches the reset values.
//  - Width rule: counters are 9 bit. Parameters must fit 0..511; the bench
//    asserts this at elaboration.
// TESTING
//  1 NTSC, sd=0: ce_pix spacing 4 clk; frame_start period 262*228*4=238944
//    clk; HSync 17 ticks at hcount 180; VSync 3 lines at vcount 244.
//  2 PAL, sd=0: frame_start period 312*228*4=284544 clk; VBlank rises at
//    vcount 288; VSync covers lines 296..298.
//  3 pal toggles 0->1 at line 100: pal_active stays 0 until the frame
//    boundary. The following frame measures 284544 clk.
//  4 scandouble=1: ce_pix spacing 2 clk; line_rep alternates each line;
//    vcount reaches 261 once; frame period stays 238944 clk.
//  5 reset pulsed 1 clk at (150,120): next cycle all outputs 0. First ce_pix
//    1 clk after release, at (0,0) with frame_start=1.

Source files
------------

// File: rtl/odyssey_video_timing.sv
// Odyssey video timing: pixel strobe divider plus H/V raster sequencer.
// Produces registered blank/sync decodes. The PAL and scandouble modes are
// latched only at frame boundaries, so a mode change never cuts a frame short.
//
// state        | meaning
// restart      | first strobe after reset is pixel (0,0), not an advance
// sd_active    | scandouble in effect: half pixel period, each line drawn twice
// pal_active   | PAL line count and decodes in effect
module odyssey_video_timing #(
    parameter int CLK_DIV      = 4,
    parameter int H_TOTAL      = 228,
    parameter int H_ACTIVE     = 160,
    parameter int H_SYNC_START = 180,
    parameter int H_SYNC_LEN   = 17,
    parameter int V_TOTAL_N    = 262,
    parameter int V_TOTAL_P    = 312,
    parameter int V_ACTIVE_N   = 240,
    parameter int V_ACTIVE_P   = 288,
    parameter int V_SYNC_N     = 244,
    parameter int V_SYNC_P     = 296,
    parameter int V_SYNC_LEN   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pal,
    input  logic       scandouble,
    output logic       ce_pix,
    output logic [8:0] hcount,
    output logic [8:0] vcount,
    output logic       line_rep,
    output logic       HBlank,
    output logic       VBlank,
    output logic       HSync,
    output logic       VSync,
    output logic       frame_start,
    output logic       pal_active
);

    localparam logic [8:0] H_LAST  = 9'(H_TOTAL - 1);
    localparam logic [8:0] H_ACT   = 9'(H_ACTIVE);
    localparam logic [8:0] HS_BEG  = 9'(H_SYNC_START);
    localparam logic [8:0] HS_END  = 9'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [8:0] VN_LAST = 9'(V_TOTAL_N - 1);
    localparam logic [8:0] VP_LAST = 9'(V_TOTAL_P - 1);
    localparam logic [8:0] VN_ACT  = 9'(V_ACTIVE_N);
    localparam logic [8:0] VP_ACT  = 9'(V_ACTIVE_P);
    localparam logic [8:0] VSN_BEG = 9'(V_SYNC_N);
    localparam logic [8:0] VSN_END = 9'(V_SYNC_N + V_SYNC_LEN);
    localparam logic [8:0] VSP_BEG = 9'(V_SYNC_P);
    localparam logic [8:0] VSP_END = 9'(V_SYNC_P + V_SYNC_LEN);
    localparam logic [7:0] DIV_FULL = 8'(CLK_DIV - 1);
    localparam logic [7:0] DIV_HALF = 8'(CLK_DIV / 2 - 1);

    logic       sd_active;
    logic       restart;
    logic [7:0] div_cnt;
    logic       line_end;
    logic       line_last_copy;
    logic       frame_end;
    logic       pal_nx;
    logic       sd_nx;
    logic [8:0] h_nx;
    logic [8:0] v_nx;
    logic       rep_nx;
    logic [8:0] v_last;
    logic [8:0] v_act;
    logic [8:0] vs_beg;
    logic [8:0] vs_end;
    logic [7:0] div_load;

    // Next raster position and the mode that will be in effect for it.
    always_comb begin
        line_end       = (hcount == H_LAST);
        line_last_copy = line_end && (!sd_active || line_rep);
        v_last         = pal_active ? VP_LAST : VN_LAST;
        frame_end      = line_last_copy && (vcount == v_last);
        pal_nx         = frame_end ? pal : pal_active;
        sd_nx          = frame_end ? scandouble : sd_active;
        h_nx           = hcount + 9'd1;
        v_nx           = vcount;
        rep_nx         = line_rep;
        if (restart || frame_end) begin
            h_nx   = 9'd0;
            v_nx   = 9'd0;
            rep_nx = 1'b0;
        end else if (line_end) begin
            h_nx   = 9'd0;
            v_nx   = line_last_copy ? vcount + 9'd1 : vcount;
            rep_nx = sd_active ? ~line_rep : 1'b0;
        end
        // Vertical decodes follow the mode of the pixel being strobed.
        v_act    = pal_nx ? VP_ACT  : VN_ACT;
        vs_beg   = pal_nx ? VSP_BEG : VSN_BEG;
        vs_end   = pal_nx ? VSP_END : VSN_END;
        div_load = sd_nx ? DIV_HALF : DIV_FULL;
    end

    // Down-counting pixel divider; every output updates on the strobe edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ce_pix      <= 1'b0;
            hcount      <= 9'd0;
            vcount      <= 9'd0;
            line_rep    <= 1'b0;
            HBlank      <= 1'b0;
            VBlank      <= 1'b0;
            HSync       <= 1'b0;
            VSync       <= 1'b0;
            frame_start <= 1'b0;
            pal_active  <= pal;
            sd_active   <= scandouble;
            restart     <= 1'b1;
            div_cnt     <= 8'd0;
        end else begin
            ce_pix <= (div_cnt == 8'd0);
            if (div_cnt == 8'd0) begin
                div_cnt     <= div_load;
                restart     <= 1'b0;
                hcount      <= h_nx;
                vcount      <= v_nx;
                line_rep    <= rep_nx;
                pal_active  <= pal_nx;
                sd_active   <= sd_nx;
                frame_start <= restart || frame_end;
                HBlank      <= (h_nx >= H_ACT);
                HSync       <= (h_nx >= HS_BEG) && (h_nx < HS_END);
                VBlank      <= (v_nx >= v_act);
                VSync       <= (v_nx >= vs_beg) && (v_nx < vs_end);
            end else begin
                div_cnt <= div_cnt - 8'd1;
            end
        end
    end

endmodule
